// File: rtl/smart_cargo_pkg.sv
// Shared constants, state encodings and frame-byte helpers for the cargo-lift
// status transmitter.
package smart_cargo_pkg;

    localparam int FRAME_LEN = 6;

    localparam logic [7:0] CH_A    = 8'h41;
    localparam logic [7:0] CH_P    = 8'h50;
    localparam logic [7:0] CH_E    = 8'h45;
    localparam logic [7:0] CH_X    = 8'h58;
    localparam logic [7:0] CH_S    = 8'h53;
    localparam logic [7:0] CH_D    = 8'h44;
    localparam logic [7:0] CH_H    = 8'h48;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_ZERO = 8'h30;

    // Values double as the db_estado debug code.
    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        CARREGA = 4'd1,
        START   = 4'd2,
        DADOS   = 4'd3,
        STOP    = 4'd4,
        GAP     = 4'd5,
        FIM     = 4'd6
    } estado_t;

    typedef enum logic [1:0] {
        B_OCIOSO = 2'd0,
        B_START  = 2'd1,
        B_DADOS  = 2'd2,
        B_STOP   = 2'd3
    } fase_t;

    typedef struct packed {
        logic [1:0] andar;
        logic [1:0] prox;
        logic       subindo;
        logic       descendo;
        logic       emerg;
    } snap_t;

    function automatic logic [7:0] motor_char(snap_t s);
        if (s.emerg)                     return CH_E;
        else if (s.subindo && s.descendo) return CH_X;
        else if (s.subindo)              return CH_S;
        else if (s.descendo)             return CH_D;
        else                             return CH_H;
    endfunction

    function automatic logic [7:0] frame_byte(logic [2:0] idx, snap_t s);
        case (idx)
            3'd0:    return CH_A;
            3'd1:    return CH_ZERO + {6'd0, s.andar};
            3'd2:    return CH_P;
            3'd3:    return CH_ZERO + {6'd0, s.prox};
            3'd4:    return motor_char(s);
            default: return CH_LF;
        endcase
    endfunction

endpackage

// File: rtl/smart_cargo_status_tx_uart.sv
// 8N1 byte serialiser: one start bit, eight data bits LSB first, one stop bit.
// fim_byte flags the last cycle of the stop bit so the caller can chain bytes.
module uart_tx_byte
    import smart_cargo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] dado,
    input  logic       partida,
    output logic       TX,
    output logic       fim_byte,
    output fase_t      fase_prox
);

    localparam int             CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_MAX = CW'(CLKS_PER_BIT - 1);

    fase_t         fase_q, fase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    dado_q, dado_d;
    logic          tx_q, tx_d;
    logic          ultimo;

    assign ultimo = (cnt_q == CNT_MAX);

    always_ff @(posedge clock) begin
        if (!reset) begin
            fase_q <= B_OCIOSO;
            cnt_q  <= '0;
            bit_q  <= '0;
            dado_q <= '0;
            tx_q   <= 1'b1;
        end else begin
            fase_q <= fase_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            dado_q <= dado_d;
            tx_q   <= tx_d;
        end
    end

    always_comb begin
        fase_d = fase_q;
        cnt_d  = cnt_q;
        bit_d  = bit_q;
        dado_d = dado_q;
        case (fase_q)
            B_OCIOSO: if (partida) begin
                fase_d = B_START;
                cnt_d  = '0;
                dado_d = dado;
            end
            B_START: if (ultimo) begin
                fase_d = B_DADOS;
                cnt_d  = '0;
                bit_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            B_DADOS: if (ultimo) begin
                cnt_d = '0;
                if (bit_q == 3'd7) fase_d = B_STOP;
                else               bit_d  = bit_q + 3'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            B_STOP: if (ultimo) begin
                fase_d = B_OCIOSO;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        endcase
    end

    // TX is registered from the next phase so the line changes exactly on bit boundaries.
    always_comb begin
        tx_d = 1'b1;
        case (fase_d)
            B_START: tx_d = 1'b0;
            B_DADOS: tx_d = dado_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    assign TX        = tx_q;
    assign fim_byte  = (fase_q == B_STOP) && ultimo;
    assign fase_prox = fase_d;

endmodule

// File: rtl/smart_cargo_status_tx.sv
// Cargo-lift status reporter: on request, snapshots floor/stop/motor state and
// sends "A<f>P<s><m>\n" over 8N1 UART, with a one-deep pending request.
module smart_cargo_status_tx
    import smart_cargo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enviar,
    input  logic [1:0] andarAtual,
    input  logic [1:0] proxParada,
    input  logic       motorSubindo,
    input  logic       motorDescendo,
    input  logic       emergencia,
    output logic       TX,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    estado_t    est_q, est_d;
    snap_t      snap_q, snap_d;
    logic [2:0] idx_q, idx_d;
    logic       pend_q, pend_d;
    logic       ocup_q, ocup_d;
    logic       pronto_q, pronto_d;
    logic [3:0] db_q, db_d;

    logic       partida;
    logic       fim_byte;
    logic [7:0] dado;
    fase_t      fase_prox;

    // Byte 0 is a constant, so CARREGA can launch it before the snapshot lands.
    assign dado    = frame_byte((est_q == CARREGA) ? 3'd0 : idx_q, snap_q);
    assign partida = (est_q == CARREGA) || (est_q == GAP);

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
        .clock    (clock),
        .reset    (reset),
        .dado     (dado),
        .partida  (partida),
        .TX       (TX),
        .fim_byte (fim_byte),
        .fase_prox(fase_prox)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            est_q    <= OCIOSO;
            snap_q   <= '0;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            ocup_q   <= 1'b0;
            pronto_q <= 1'b0;
            db_q     <= '0;
        end else begin
            est_q    <= est_d;
            snap_q   <= snap_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            ocup_q   <= ocup_d;
            pronto_q <= pronto_d;
            db_q     <= db_d;
        end
    end

    always_comb begin
        est_d  = est_q;
        snap_d = snap_q;
        idx_d  = idx_q;
        pend_d = pend_q | (enviar && (est_q != OCIOSO));
        case (est_q)
            OCIOSO:  if (enviar) est_d = CARREGA;
            CARREGA: begin
                snap_d = '{andar: andarAtual, prox: proxParada, subindo: motorSubindo,
                           descendo: motorDescendo, emerg: emergencia};
                idx_d  = '0;
                est_d  = START;
            end
            START, DADOS, STOP: begin
                if (fim_byte) begin
                    if (idx_q < 3'(FRAME_LEN - 1)) begin
                        idx_d = idx_q + 3'd1;
                        est_d = GAP;
                    end else begin
                        est_d = FIM;
                    end
                end else begin
                    case (fase_prox)
                        B_START: est_d = START;
                        B_DADOS: est_d = DADOS;
                        B_STOP:  est_d = STOP;
                        default: est_d = est_q;
                    endcase
                end
            end
            GAP:     est_d = START;
            FIM: begin
                // A request landing on FIM itself is honoured like a pending one.
                if (pend_q || enviar) begin
                    est_d  = CARREGA;
                    pend_d = 1'b0;
                end else begin
                    est_d  = OCIOSO;
                end
            end
            default: est_d = OCIOSO;
        endcase
    end

    always_comb begin
        ocup_d   = (est_d != OCIOSO);
        pronto_d = (est_d == FIM);
        db_d     = est_d;
    end

    assign ocupado   = ocup_q;
    assign pronto    = pronto_q;
    assign db_estado = db_q;

endmodule
